byteswap_burst_sched: RTL and testbench

//  Sequencer for the in-place byteswap kernel. On ap_start it splits the job (gmem_ptr, xfer_size_bytes) into AXI

---
 rtl/byteswap_burst_sched.sv | 252 +++++++++++++++++++++++++
 tb/tb_byteswap_burst_sched.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/byteswap_burst_sched.sv
// Burst sequencer for the in-place byteswap kernel.
//
// Accepts a job on ap_start: a base pointer (gmem_ptr) and a length
// (xfer_size_bytes). It splits the job into AXI bursts and issues read
// commands, then issues the write-back command for each burst after
// that burst's read completes. A credit limit caps the number of bursts
// that have been read-issued but not yet write-completed.
//
// Ports:
//   ap_clk, ap_rst_n           clock, asynchronous active-low reset
//   ap_start/done/idle/ready   ap_ctrl_hs handshake
//   xfer_size_bytes, gmem_ptr  job description, sampled on accept
//   rd_cmd_*                   read burst command (valid/ready)
//   wr_cmd_*                   write burst command (valid/ready)
//   rd_done, wr_done           per-burst completion pulses
module byteswap_burst_sched #(
    parameter int C_M_AXI_GMEM_ADDR_WIDTH = 64,
    parameter int C_XFER_SIZE_WIDTH       = 32,
    parameter int C_BYTES_PER_BEAT        = 4,
    parameter int C_MAX_BURST_BEATS       = 16,
    parameter int C_MAX_OUTSTANDING       = 4
) (
    input  logic                               ap_clk,
    input  logic                               ap_rst_n,
    input  logic                               ap_start,
    output logic                               ap_done,
    output logic                               ap_idle,
    output logic                               ap_ready,
    input  logic [C_XFER_SIZE_WIDTH-1:0]       xfer_size_bytes,
    input  logic [C_M_AXI_GMEM_ADDR_WIDTH-1:0] gmem_ptr,
    output logic                               rd_cmd_valid,
    input  logic                               rd_cmd_ready,
    output logic [C_M_AXI_GMEM_ADDR_WIDTH-1:0] rd_cmd_addr,
    output logic [7:0]                         rd_cmd_len,
    output logic                               wr_cmd_valid,
    input  logic                               wr_cmd_ready,
    output logic [C_M_AXI_GMEM_ADDR_WIDTH-1:0] wr_cmd_addr,
    output logic [7:0]                         wr_cmd_len,
    input  logic                               rd_done,
    input  logic                               wr_done
);

    localparam int AW        = C_M_AXI_GMEM_ADDR_WIDTH;
    localparam int XS        = C_XFER_SIZE_WIDTH;
    localparam int LOG_BPB   = $clog2(C_BYTES_PER_BEAT);
    localparam int LOG_MAX   = $clog2(C_MAX_BURST_BEATS);
    localparam int LOG_BURST = LOG_BPB + LOG_MAX;

    localparam logic [XS:0]   BEAT_RND  = (XS+1)'(C_BYTES_PER_BEAT - 1);
    localparam logic [XS:0]   BURST_RND = (XS+1)'(C_MAX_BURST_BEATS - 1);
    localparam logic [XS:0]   ONE_W     = (XS+1)'(1);
    localparam logic [XS-1:0] ONE       = XS'(1);
    localparam logic [XS-1:0] CREDITS   = XS'(C_MAX_OUTSTANDING);
    localparam logic [7:0]    FULL_LEN  = 8'(C_MAX_BURST_BEATS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_RUN,
        S_DONE
    } state_e;

    state_e state_q, state_d;

    logic [AW-1:0] ptr_q, ptr_d;
    logic [XS-1:0] size_q, size_d;
    logic [XS-1:0] nbursts_q, nbursts_d;
    logic [7:0]    last_len_q, last_len_d;

    logic [XS-1:0] rd_iss_q, rd_iss_d;
    logic [XS-1:0] wr_iss_q, wr_iss_d;
    logic [XS-1:0] rd_cmp_q, rd_cmp_d;
    logic [XS-1:0] wr_cmp_q, wr_cmp_d;

    logic          rd_vld_q, rd_vld_d;
    logic [AW-1:0] rd_addr_q, rd_addr_d;
    logic [7:0]    rd_len_q, rd_len_d;
    logic          wr_vld_q, wr_vld_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]    wr_len_q, wr_len_d;

    // One extra bit so a maximum-size job cannot overflow the rounding.
    logic [XS:0] calc_beats;
    logic [XS:0] calc_bursts;
    logic [XS:0] calc_last;

    assign calc_beats  = ({1'b0, size_q} + BEAT_RND) >> LOG_BPB;
    assign calc_bursts = (calc_beats + BURST_RND) >> LOG_MAX;
    assign calc_last   = (calc_beats - ONE_W) & BURST_RND;

    function automatic logic [AW-1:0] burst_addr(
        input logic [AW-1:0] base,
        input logic [XS-1:0] idx
    );
        return base + (AW'(idx) << LOG_BURST);
    endfunction

    // Only the final burst of a job can be short.
    function automatic logic [7:0] burst_len(
        input logic [XS-1:0] idx,
        input logic [XS-1:0] nb,
        input logic [7:0]    last
    );
        return (idx == nb - ONE) ? last : FULL_LEN;
    endfunction

    // State register
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (ap_start) state_d = S_CALC;
            end
            S_CALC: begin
                state_d = (calc_beats == '0) ? S_DONE : S_RUN;
            end
            S_RUN: begin
                if (wr_cmp_q == nbursts_q) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control outputs
    always_comb begin
        ap_idle = 1'b0;
        ap_done = 1'b0;
        unique case (state_q)
            S_IDLE:  ap_idle = 1'b1;
            S_DONE:  ap_done = 1'b1;
            default: ;
        endcase
        ap_ready = ap_done;
    end

    // Job registers, counters and command registers
    always_comb begin
        ptr_d      = ptr_q;
        size_d     = size_q;
        nbursts_d  = nbursts_q;
        last_len_d = last_len_q;
        rd_iss_d   = rd_iss_q;
        wr_iss_d   = wr_iss_q;
        rd_cmp_d   = rd_cmp_q;
        wr_cmp_d   = wr_cmp_q;
        rd_vld_d   = rd_vld_q;
        rd_addr_d  = rd_addr_q;
        rd_len_d   = rd_len_q;
        wr_vld_d   = wr_vld_q;
        wr_addr_d  = wr_addr_q;
        wr_len_d   = wr_len_q;

        unique case (state_q)
            S_IDLE: begin
                if (ap_start) begin
                    ptr_d    = gmem_ptr;
                    size_d   = xfer_size_bytes;
                    rd_iss_d = '0;
                    wr_iss_d = '0;
                    rd_cmp_d = '0;
                    wr_cmp_d = '0;
                end
            end
            S_CALC: begin
                nbursts_d  = XS'(calc_bursts);
                last_len_d = 8'(calc_last);
            end
            S_RUN: begin
                if (rd_vld_q && rd_cmd_ready) rd_iss_d = rd_iss_q + ONE;
                if (wr_vld_q && wr_cmd_ready) wr_iss_d = wr_iss_q + ONE;
                // Completion pulses without an outstanding burst are dropped.
                if (rd_done && (rd_cmp_q < rd_iss_q)) rd_cmp_d = rd_cmp_q + ONE;
                if (wr_done && (wr_cmp_q < wr_iss_q)) wr_cmp_d = wr_cmp_q + ONE;
            end
            default: ;
        endcase

        // A stalled command holds; otherwise present the next eligible one
        // using the post-handshake counts so commands can go back-to-back.
        if (!(rd_vld_q && !rd_cmd_ready)) begin
            rd_vld_d  = (state_q == S_RUN)
                     && (rd_iss_d < nbursts_q)
                     && ((rd_iss_d - wr_cmp_d) < CREDITS);
            rd_addr_d = rd_vld_d ? burst_addr(ptr_q, rd_iss_d) : '0;
            rd_len_d  = rd_vld_d
                      ? burst_len(rd_iss_d, nbursts_q, last_len_q) : '0;
        end

        if (!(wr_vld_q && !wr_cmd_ready)) begin
            wr_vld_d  = (state_q == S_RUN)
                     && (wr_iss_d < nbursts_q)
                     && (rd_cmp_d > wr_iss_d);
            wr_addr_d = wr_vld_d ? burst_addr(ptr_q, wr_iss_d) : '0;
            wr_len_d  = wr_vld_d
                      ? burst_len(wr_iss_d, nbursts_q, last_len_q) : '0;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            ptr_q      <= '0;
            size_q     <= '0;
            nbursts_q  <= '0;
            last_len_q <= '0;
            rd_iss_q   <= '0;
            wr_iss_q   <= '0;
            rd_cmp_q   <= '0;
            wr_cmp_q   <= '0;
            rd_vld_q   <= 1'b0;
            rd_addr_q  <= '0;
            rd_len_q   <= '0;
            wr_vld_q   <= 1'b0;
            wr_addr_q  <= '0;
            wr_len_q   <= '0;
        end else begin
            ptr_q      <= ptr_d;
            size_q     <= size_d;
            nbursts_q  <= nbursts_d;
            last_len_q <= last_len_d;
            rd_iss_q   <= rd_iss_d;
            wr_iss_q   <= wr_iss_d;
            rd_cmp_q   <= rd_cmp_d;
            wr_cmp_q   <= wr_cmp_d;
            rd_vld_q   <= rd_vld_d;
            rd_addr_q  <= rd_addr_d;
            rd_len_q   <= rd_len_d;
            wr_vld_q   <= wr_vld_d;
            wr_addr_q  <= wr_addr_d;
            wr_len_q   <= wr_len_d;
        end
    end

    assign rd_cmd_valid = rd_vld_q;
    assign rd_cmd_addr  = rd_addr_q;
    assign rd_cmd_len   = rd_len_q;
    assign wr_cmd_valid = wr_vld_q;
    assign wr_cmd_addr  = wr_addr_q;
    assign wr_cmd_len   = wr_len_q;

endmodule

// File: tb/tb_byteswap_burst_sched.sv
// Testbench for byteswap_burst_sched.
// Job-level model plus per-cycle protocol checks and directed literals.
module tb_byteswap_burst_sched;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n;
    logic        ap_start;
    logic        ap_done, ap_idle, ap_ready;
    logic [31:0] xfer_size_bytes;
    logic [63:0] gmem_ptr;
    logic        rd_cmd_valid, rd_cmd_ready;
    logic [63:0] rd_cmd_addr;
    logic [7:0]  rd_cmd_len;
    logic        wr_cmd_valid, wr_cmd_ready;
    logic [63:0] wr_cmd_addr;
    logic [7:0]  wr_cmd_len;
    logic        rd_done, wr_done;

    byteswap_burst_sched dut (
        .ap_clk          (ap_clk),
        .ap_rst_n        (ap_rst_n),
        .ap_start        (ap_start),
        .ap_done         (ap_done),
        .ap_idle         (ap_idle),
        .ap_ready        (ap_ready),
        .xfer_size_bytes (xfer_size_bytes),
        .gmem_ptr        (gmem_ptr),
        .rd_cmd_valid    (rd_cmd_valid),
        .rd_cmd_ready    (rd_cmd_ready),
        .rd_cmd_addr     (rd_cmd_addr),
        .rd_cmd_len      (rd_cmd_len),
        .wr_cmd_valid    (wr_cmd_valid),
        .wr_cmd_ready    (wr_cmd_ready),
        .wr_cmd_addr     (wr_cmd_addr),
        .wr_cmd_len      (wr_cmd_len),
        .rd_done         (rd_done),
        .wr_done         (wr_done)
    );

    always #5 ap_clk = ~ap_clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    // Job model
    logic [63:0] m_ptr = '0;
    logic [31:0] m_size = '0;
    longint      m_tb = 0;
    longint      m_nb = 0;
    longint      m_rd_iss = 0, m_wr_iss = 0, m_rd_cmp = 0, m_wr_cmp = 0;
    bit          m_busy = 1'b0;
    int          acc_cyc = 0, done_cyc = 0, done_cnt = 0;

    logic [63:0] rd_alog[$], wr_alog[$];
    logic [7:0]  rd_llog[$], wr_llog[$];
    int          rdq[$], wrq[$];
    bit          wr_hold = 1'b0;
    bit          man_rd = 1'b0, man_wr = 1'b0;

    bit          prv_rv = 1'b0, prv_rr = 1'b0, prv_wv = 1'b0, prv_wr = 1'b0;
    logic [63:0] prv_ra = '0, prv_wa = '0;
    logic [7:0]  prv_rl = '0, prv_wl = '0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] exp_addr(input longint i);
        return m_ptr + 64'(i) * 64'd64;
    endfunction

    function automatic logic [7:0] exp_len(input longint i);
        if (i == m_nb - 1) return 8'((m_tb - 1) % 16);
        return 8'd15;
    endfunction

    // Completion responder: pulses 5 cycles after each handshake.
    always @(posedge ap_clk) begin
        cyc = cyc + 1;
        #1;
        if (!ap_rst_n) begin
            rdq.delete();
            wrq.delete();
            rd_done = 1'b0;
            wr_done = 1'b0;
            man_rd  = 1'b0;
            man_wr  = 1'b0;
        end else begin
            rd_done = man_rd;
            wr_done = man_wr;
            man_rd  = 1'b0;
            man_wr  = 1'b0;
            if (rdq.size() > 0 && rdq[0] <= cyc) begin
                rd_done = 1'b1;
                void'(rdq.pop_front());
            end
            if (wrq.size() > 0 && wrq[0] <= cyc) begin
                wr_done = 1'b1;
                void'(wrq.pop_front());
            end
        end
    end

    // Per-cycle compare against the job model.
    always @(negedge ap_clk) begin
        if (!ap_rst_n) begin
            m_busy = 1'b0;
            prv_rv = 1'b0;
            prv_wv = 1'b0;
        end else begin
            chk("ap_idle", 64'(ap_idle), 64'(!m_busy));
            chk("ap_ready", 64'(ap_ready), 64'(ap_done));
            if (!m_busy) begin
                chk("rd_valid_idle", 64'(rd_cmd_valid), 64'd0);
                chk("wr_valid_idle", 64'(wr_cmd_valid), 64'd0);
            end
            if (prv_rv && !prv_rr) begin
                chk("rd_hold_valid", 64'(rd_cmd_valid), 64'd1);
                chk("rd_hold_addr", rd_cmd_addr, prv_ra);
                chk("rd_hold_len", 64'(rd_cmd_len), 64'(prv_rl));
            end
            if (prv_wv && !prv_wr) begin
                chk("wr_hold_valid", 64'(wr_cmd_valid), 64'd1);
                chk("wr_hold_addr", wr_cmd_addr, prv_wa);
                chk("wr_hold_len", 64'(wr_cmd_len), 64'(prv_wl));
            end
            if (rd_cmd_valid) begin
                chk("rd_in_range", 64'(m_rd_iss < m_nb), 64'd1);
                chk("rd_credit", 64'(m_rd_iss - m_wr_cmp < 4), 64'd1);
                chk("rd_addr", rd_cmd_addr, exp_addr(m_rd_iss));
                chk("rd_len", 64'(rd_cmd_len), 64'(exp_len(m_rd_iss)));
            end
            if (wr_cmd_valid) begin
                chk("wr_in_range", 64'(m_wr_iss < m_nb), 64'd1);
                chk("wr_after_rd", 64'(m_rd_cmp > m_wr_iss), 64'd1);
                chk("wr_addr", wr_cmd_addr, exp_addr(m_wr_iss));
                chk("wr_len", 64'(wr_cmd_len), 64'(exp_len(m_wr_iss)));
            end
            if (ap_done) begin
                chk("done_when", 64'(m_busy && m_wr_cmp == m_nb), 64'd1);
                done_cnt++;
                done_cyc = cyc;
            end
            if (rd_done && m_rd_cmp < m_rd_iss) m_rd_cmp++;
            if (wr_done && m_wr_cmp < m_wr_iss) m_wr_cmp++;
            if (rd_cmd_valid && rd_cmd_ready) begin
                rd_alog.push_back(rd_cmd_addr);
                rd_llog.push_back(rd_cmd_len);
                rdq.push_back(cyc + 5);
                m_rd_iss++;
            end
            if (wr_cmd_valid && wr_cmd_ready) begin
                wr_alog.push_back(wr_cmd_addr);
                wr_llog.push_back(wr_cmd_len);
                if (!wr_hold) wrq.push_back(cyc + 5);
                m_wr_iss++;
            end
            prv_rv = rd_cmd_valid; prv_rr = rd_cmd_ready;
            prv_ra = rd_cmd_addr;  prv_rl = rd_cmd_len;
            prv_wv = wr_cmd_valid; prv_wr = wr_cmd_ready;
            prv_wa = wr_cmd_addr;  prv_wl = wr_cmd_len;
            if (ap_done) begin
                m_busy = 1'b0;
            end else if (!m_busy && ap_start) begin
                m_busy   = 1'b1;
                acc_cyc  = cyc;
                m_tb     = (longint'(m_size) + 3) / 4;
                m_nb     = (m_tb + 15) / 16;
                m_rd_iss = 0; m_wr_iss = 0;
                m_rd_cmp = 0; m_wr_cmp = 0;
                rd_alog.delete(); rd_llog.delete();
                wr_alog.delete(); wr_llog.delete();
            end
        end
    end

    task automatic start_job(input logic [63:0] p, input logic [31:0] s);
        @(posedge ap_clk); #1;
        m_ptr = p;
        m_size = s;
        gmem_ptr = p;
        xfer_size_bytes = s;
        ap_start = 1'b1;
        @(posedge ap_clk); #1;
        ap_start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input string nm);
        for (int i = 0; i < 800 && done_cnt == d0; i++) @(posedge ap_clk);
        chk(nm, 64'(done_cnt), 64'(d0 + 1));
        repeat (2) @(posedge ap_clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge ap_clk); #1;
        ap_rst_n = 1'b0;
        #1;
        chk("rst_rd_valid", 64'(rd_cmd_valid), 64'd0);
        chk("rst_rd_addr", rd_cmd_addr, 64'd0);
        chk("rst_rd_len", 64'(rd_cmd_len), 64'd0);
        chk("rst_wr_valid", 64'(wr_cmd_valid), 64'd0);
        chk("rst_wr_addr", wr_cmd_addr, 64'd0);
        chk("rst_wr_len", 64'(wr_cmd_len), 64'd0);
        chk("rst_idle", 64'(ap_idle), 64'd1);
        chk("rst_done", 64'(ap_done), 64'd0);
        chk("rst_ready", 64'(ap_ready), 64'd0);
        repeat (2) @(posedge ap_clk);
        #1;
        ap_rst_n = 1'b1;
    endtask

    task automatic chk_log(input string nm, input int n,
                           input logic [63:0] base, input logic [7:0] last);
        chk({nm, "_rd_n"}, 64'(rd_alog.size()), 64'(n));
        chk({nm, "_wr_n"}, 64'(wr_alog.size()), 64'(n));
        for (int i = 0; i < n && i < rd_alog.size() && i < wr_alog.size(); i++) begin
            chk({nm, "_rd_a"}, rd_alog[i], base + 64'(i) * 64'h40);
            chk({nm, "_wr_a"}, wr_alog[i], base + 64'(i) * 64'h40);
            chk({nm, "_rd_l"}, 64'(rd_llog[i]), (i == n - 1) ? 64'(last) : 64'd15);
            chk({nm, "_wr_l"}, 64'(wr_llog[i]), (i == n - 1) ? 64'(last) : 64'd15);
        end
    endtask

    initial begin
        int d0;
        ap_rst_n = 1'b0;
        ap_start = 1'b0;
        gmem_ptr = '0;
        xfer_size_bytes = '0;
        rd_cmd_ready = 1'b1;
        wr_cmd_ready = 1'b1;
        rd_done = 1'b0;
        wr_done = 1'b0;
        repeat (3) @(posedge ap_clk);
        #1;
        chk("init_idle", 64'(ap_idle), 64'd1);
        chk("init_done", 64'(ap_done), 64'd0);
        chk("init_rd_valid", 64'(rd_cmd_valid), 64'd0);
        chk("init_wr_valid", 64'(wr_cmd_valid), 64'd0);
        chk("init_rd_addr", rd_cmd_addr, 64'd0);
        ap_rst_n = 1'b1;

        // Four full bursts
        d0 = done_cnt;
        start_job(64'h1000, 32'd256);
        wait_done(d0, "t1_done");
        chk_log("t1", 4, 64'h1000, 8'd15);

        // 18 beats: one full and one 2-beat burst, plus a stray rd_done
        d0 = done_cnt;
        start_job(64'h1000, 32'd70);
        @(negedge ap_clk);
        man_rd = 1'b1;
        wait_done(d0, "t2_done");
        chk_log("t2", 2, 64'h1000, 8'd1);

        // Empty job
        d0 = done_cnt;
        start_job(64'h2000, 32'd0);
        wait_done(d0, "t3_done");
        chk("t3_latency", 64'(done_cyc - acc_cyc), 64'd2);
        chk("t3_rd_n", 64'(rd_alog.size()), 64'd0);
        chk("t3_wr_n", 64'(wr_alog.size()), 64'd0);

        // Read command stalled for 10 cycles
        rd_cmd_ready = 1'b0;
        d0 = done_cnt;
        start_job(64'h1000, 32'd256);
        for (int i = 0; i < 50 && !rd_cmd_valid; i++) @(negedge ap_clk);
        chk("t5_valid_seen", 64'(rd_cmd_valid), 64'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge ap_clk);
            chk("t5_stall_valid", 64'(rd_cmd_valid), 64'd1);
            chk("t5_stall_addr", rd_cmd_addr, 64'h1000);
            chk("t5_stall_len", 64'(rd_cmd_len), 64'd15);
        end
        @(posedge ap_clk); #1;
        rd_cmd_ready = 1'b1;
        wait_done(d0, "t5_done");
        chk_log("t5", 4, 64'h1000, 8'd15);

        // Credit cap with write completions withheld
        wr_hold = 1'b1;
        start_job(64'h1000, 32'd4096);
        repeat (80) @(posedge ap_clk);
        chk("t4_cap", 64'(rd_alog.size()), 64'd4);
        for (int k = 0; k < 3; k++) begin
            @(negedge ap_clk);
            man_wr = 1'b1;
            repeat (20) @(posedge ap_clk);
            chk("t4_release", 64'(rd_alog.size()), 64'(5 + k));
        end
        do_reset();
        wr_hold = 1'b0;

        // Reset mid-job, then a fresh single-burst job
        start_job(64'h1000, 32'd256);
        for (int i = 0; i < 100 && rd_alog.size() < 2; i++) @(posedge ap_clk);
        chk("t6_two_rd", 64'(rd_alog.size() >= 2), 64'd1);
        do_reset();
        repeat (2) @(posedge ap_clk);
        d0 = done_cnt;
        start_job(64'h8000, 32'd64);
        wait_done(d0, "t6_done");
        chk_log("t6", 1, 64'h8000, 8'd15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
